// File: rtl/snake_pkg.sv
// Shared snake-game definitions: direction codes, button indices and the reversal helper.
// Imported by the game core and by the direction controller.
package snake_pkg;

    typedef logic [2:0] dir_t;

    localparam dir_t STAY  = 3'd0;
    localparam dir_t UP    = 3'd1;
    localparam dir_t DOWN  = 3'd2;
    localparam dir_t RIGHT = 3'd3;
    localparam dir_t LEFT  = 3'd4;

    // Bit positions inside the {up,down,right,left} button vector
    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_UP    = 3;
    localparam int NUM_BTN   = 4;

    function automatic dir_t opposite(input dir_t d);
        case (d)
            UP:      return DOWN;
            DOWN:    return UP;
            RIGHT:   return LEFT;
            LEFT:    return RIGHT;
            default: return STAY;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button conditioner: synchroniser chain, stable-level debounce counter,
// and a registered one-cycle pulse on each debounced rising edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_stable;
    logic                   r_stable_d;
    logic                   r_press;
    logic                   w_sync;

    assign w_sync  = r_sync[SYNC_STAGES-1];
    assign o_level = r_stable;
    assign o_press = r_press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync     <= '0;
            r_cnt      <= '0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_press    <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], i_btn};
            r_stable_d <= r_stable;
            r_press    <= r_stable & ~r_stable_d;
            // Any cycle agreeing with the stable level restarts the window
            if (w_sync == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == TERM) begin
                r_stable <= ~r_stable;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/snake_dir_ctrl.sv
// Snake direction command producer: debounces four buttons, arbitrates presses,
// rejects reversals and commits the pending direction once per game step.
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       update,
    input  logic       freeze,
    input  logic       clear,
    output logic [2:0] dir,
    output logic       dir_changed,
    output logic [3:0] btn_level
);

    logic [NUM_BTN-1:0] w_raw;
    logic [NUM_BTN-1:0] w_press;
    dir_t               w_cand;
    logic               w_cand_vld;
    logic               w_commit;
    dir_t               w_ref;
    logic               w_accept;

    dir_t r_dir;
    dir_t r_pend;
    logic r_pend_vld;
    logic r_commit_q;
    logic r_dir_chg;

    assign w_raw = {btn_up, btn_down, btn_right, btn_left};

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_btn (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_btn  (w_raw[g]),
            .o_level(btn_level[g]),
            .o_press(w_press[g])
        );
    end

    always_comb begin
        w_cand     = STAY;
        w_cand_vld = |w_press;
        if      (w_press[BTN_UP])    w_cand = UP;
        else if (w_press[BTN_DOWN])  w_cand = DOWN;
        else if (w_press[BTN_RIGHT]) w_cand = RIGHT;
        else if (w_press[BTN_LEFT])  w_cand = LEFT;
    end

    // Legality is judged against the direction that will hold after this edge
    assign w_commit = update & r_pend_vld & ~freeze;
    assign w_ref    = w_commit ? r_pend : r_dir;
    assign w_accept = w_cand_vld & ~freeze & (w_cand != w_ref) & (w_cand != opposite(w_ref));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dir      <= STAY;
            r_pend     <= STAY;
            r_pend_vld <= 1'b0;
            r_commit_q <= 1'b0;
            r_dir_chg  <= 1'b0;
        end else if (clear) begin
            r_dir      <= STAY;
            r_pend_vld <= 1'b0;
            r_commit_q <= 1'b0;
            r_dir_chg  <= 1'b0;
        end else begin
            r_commit_q <= w_commit;
            r_dir_chg  <= r_commit_q;
            if (w_commit) r_dir <= r_pend;
            if (w_accept) begin
                r_pend     <= w_cand;
                r_pend_vld <= 1'b1;
            end else if (w_commit) begin
                r_pend_vld <= 1'b0;
            end
        end
    end

    assign dir         = r_dir;
    assign dir_changed = r_dir_chg;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed bench for snake_dir_ctrl with a short debounce window.
module tb_snake_dir_ctrl;
    import snake_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic       update = 1'b0, freeze = 1'b0, clear = 1'b0;
    logic [2:0] dir;
    logic       dir_changed;
    logic [3:0] btn_level;

    int total = 0;
    int bad   = 0;

    snake_dir_ctrl #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .update     (update),
        .freeze     (freeze),
        .clear      (clear),
        .dir        (dir),
        .dir_changed(dir_changed),
        .btn_level  (btn_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_update();
        update = 1'b1;
        tick();
        update = 1'b0;
    endtask

    // Hold a button mask long enough to produce one press, then release and settle
    task automatic press(input logic [3:0] m);
        {btn_up, btn_down, btn_right, btn_left} = m;
        tick(9);
        {btn_up, btn_down, btn_right, btn_left} = 4'b0000;
        tick(8);
    endtask

    initial begin
        int npress;
        int first_k;
        logic seen;

        tick(3);
        rst_n = 1'b1;
        tick(2);
        chk("rst_dir", dir, STAY);
        chk("rst_chg", dir_changed, 0);
        chk("rst_lvl", btn_level, 0);

        // 1: press latency and commit
        btn_up = 1'b1;
        npress = 0; first_k = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (dut.w_press[BTN_UP]) begin
                npress++;
                if (first_k == 0) first_k = k;
            end
            if (k == 5) chk("t1_lvl5", btn_level, 4'b0000);
            if (k == 6) chk("t1_lvl6", btn_level, 4'b1000);
        end
        chk("t1_npress", npress, 1);
        chk("t1_lat", first_k, 7);
        chk("t1_dir_pre", dir, STAY);
        pulse_update();
        chk("t1_dir", dir, UP);
        chk("t1_chg0", dir_changed, 0);
        tick();
        chk("t1_chg1", dir_changed, 1);
        tick();
        chk("t1_chg2", dir_changed, 0);
        btn_up = 1'b0;
        tick(10);
        chk("t1_rel_lvl", btn_level, 0);

        // 2: short glitch is filtered
        btn_right = 1'b1;
        tick(3);
        btn_right = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (btn_level != 4'b0000) seen = 1'b1;
        end
        chk("t2_lvl", seen, 0);
        pulse_update();
        chk("t2_dir", dir, UP);
        tick();
        chk("t2_chg", dir_changed, 0);

        // 3: reversal rejected, last legal press wins
        press(4'b0001);
        press(4'b0100);
        chk("t3_pvld", dut.r_pend_vld, 1);
        pulse_update();
        chk("t3_dir_left", dir, LEFT);
        press(4'b0100);
        pulse_update();
        chk("t3_dir_down", dir, DOWN);

        // 4: simultaneous presses from STAY, UP has priority
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t4_clr_dir", dir, STAY);
        chk("t4_clr_pvld", dut.r_pend_vld, 0);
        press(4'b1010);
        pulse_update();
        chk("t4_dir", dir, UP);
        chk("t4_pvld", dut.r_pend_vld, 0);
        tick(2);
        pulse_update();
        chk("t4_dir_hold", dir, UP);
        tick();
        chk("t4_chg", dir_changed, 0);

        // 5: freeze discards presses, clear overrides freeze
        freeze = 1'b1;
        btn_left = 1'b1;
        tick(6);
        chk("t5_lvl_live", btn_level, 4'b0001);
        tick(3);
        btn_left = 1'b0;
        tick(8);
        pulse_update();
        seen = dir_changed;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (dir_changed) seen = 1'b1;
        end
        chk("t5_dir", dir, UP);
        chk("t5_chg", seen, 0);
        chk("t5_pvld", dut.r_pend_vld, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t5_clr", dir, STAY);
        freeze = 1'b0;

        // 7: press coincides with update; checked against the newly committed dir
        press(4'b1000);
        btn_right = 1'b1;
        tick(7);
        chk("t7_press", dut.w_press[BTN_RIGHT], 1);
        update = 1'b1;
        tick();
        update = 1'b0;
        chk("t7_dir", dir, UP);
        chk("t7_pvld", dut.r_pend_vld, 1);
        btn_right = 1'b0;
        tick(8);
        pulse_update();
        chk("t7_dir2", dir, RIGHT);

        // 6: asynchronous reset mid-debounce with the button still held
        btn_down = 1'b1;
        tick(4);
        chk("t6_cnt", dut.g_btn[BTN_DOWN].u_btn.r_cnt, 2);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_dir", dir, STAY);
        chk("t6_rst_lvl", btn_level, 0);
        tick(3);
        rst_n = 1'b1;
        npress = 0; first_k = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (dut.w_press[BTN_DOWN]) begin
                npress++;
                if (first_k == 0) first_k = k;
            end
            if (k == 6) chk("t6_lvl6", btn_level, 4'b0100);
        end
        chk("t6_npress", npress, 1);
        chk("t6_lat", first_k, 7);
        pulse_update();
        chk("t6_dir", dir, DOWN);
        btn_down = 1'b0;
        tick(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
